index_seq_3b: RTL and testbench

INDEX_SEQ_3B -- requirements
Module: index_seq_3b

---
 rtl/index_seq_3b.sv | 83 ++++++++
 tb/tb_index_seq_3b.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/index_seq_3b.sv
// index_seq_3b: 3-bit index sequencer (rotate / ping-pong / hold) feeding a 3-to-8 decoder,
// with debounced active-low run/pause and direction pushbuttons.
module index_seq_3b #(
   parameter int STEP_CNT_MAX = 24_999_999,
   parameter int DEBOUNCE_MAX = 999_999
) (
   input  logic       sclk,
   input  logic       s_rst,
   input  logic       pi_key_run,
   input  logic       pi_key_dir,
   input  logic [1:0] pi_mode,
   output logic [2:0] po_data,
   output logic       po_step,
   output logic       po_running
);
   localparam int PW = STEP_CNT_MAX > 0 ? $clog2(STEP_CNT_MAX + 1) : 1;
   localparam int DW = DEBOUNCE_MAX > 0 ? $clog2(DEBOUNCE_MAX + 1) : 1;
   localparam logic [PW-1:0] PRE_TC = PW'(STEP_CNT_MAX);
   localparam logic [DW-1:0] DB_TC = DW'(DEBOUNCE_MAX);

   logic [1:0] key_raw, key_s1, key_s2, key_acc, key_hit, press;
   logic [DW-1:0] db_cnt [2];
   logic [PW-1:0] pre;
   logic run, dir, hold, step, turn_dn, turn_up, dir_nx;
   logic [2:0] data_nx;

   assign key_raw = {pi_key_dir, pi_key_run};

   // The counter runs only while the synchronized level disagrees with the accepted one,
   // so any bounce back to the accepted level restarts the stability window.
   always_comb begin
      key_hit = '0;
      press = '0;
      for (int k = 0; k < 2; k++) begin
         key_hit[k] = key_s2[k] != key_acc[k] && db_cnt[k] == DB_TC;
         press[k] = key_hit[k] && !key_s2[k];
      end
   end

   always_ff @(posedge sclk) begin
      if (s_rst) begin
         key_s1 <= '1;
         key_s2 <= '1;
         key_acc <= '1;
         db_cnt <= '{default: '0};
      end else begin
         key_s1 <= key_raw;
         key_s2 <= key_s1;
         for (int k = 0; k < 2; k++) begin
            db_cnt[k] <= key_s2[k] == key_acc[k] || key_hit[k] ? '0 : db_cnt[k] + 1'b1;
            if (key_hit[k]) key_acc[k] <= key_s2[k];
         end
      end
   end

   // A dir press lands after the step's own end-stop reversal has been applied.
   always_comb begin
      hold = pi_mode[1];
      step = run && !hold && pre == PRE_TC;
      turn_dn = pi_mode == 2'b01 && !dir && po_data == 3'd7;
      turn_up = pi_mode == 2'b01 && dir && po_data == 3'd0;
      data_nx = turn_dn ? 3'd6 : turn_up ? 3'd1 : dir ? po_data - 3'd1 : po_data + 3'd1;
      dir_nx = (step ? dir ^ (turn_dn | turn_up) : dir) ^ press[1];
   end

   always_ff @(posedge sclk) begin
      if (s_rst) begin
         pre <= '0;
         run <= 1'b1;
         dir <= 1'b0;
         po_data <= '0;
         po_step <= 1'b0;
      end else begin
         pre <= hold || step ? '0 : run ? pre + 1'b1 : pre;
         run <= run ^ press[0];
         dir <= dir_nx;
         po_step <= step;
         if (step) po_data <= data_nx;
      end
   end

   assign po_running = run;
endmodule

// File: tb/tb_index_seq_3b.sv
// tb_index_seq_3b: directed checks of index_seq_3b with STEP_CNT_MAX=3, DEBOUNCE_MAX=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_index_seq_3b;
   logic sclk = 1'b0;
   logic s_rst = 1'b1;
   logic key_run = 1'b1;
   logic key_dir = 1'b1;
   logic [1:0] mode = 2'b00;
   logic [2:0] data;
   logic step, running;
   int n_chk = 0;
   int n_pass = 0;
   localparam int PP [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

   index_seq_3b #(.STEP_CNT_MAX(3), .DEBOUNCE_MAX(4)) dut (
      .sclk(sclk),
      .s_rst(s_rst),
      .pi_key_run(key_run),
      .pi_key_dir(key_dir),
      .pi_mode(mode),
      .po_data(data),
      .po_step(step),
      .po_running(running)
   );

   always #5 sclk = ~sclk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sclk);
         #1;
      end
   endtask

   task automatic do_reset(input logic [1:0] m);
      s_rst = 1'b1;
      key_run = 1'b1;
      key_dir = 1'b1;
      mode = m;
      tick(2);
      s_rst = 1'b0;
   endtask

   initial begin
      int saw_step;
      // reset state and rotate up
      do_reset(2'b00);
      check("rst_data", data, 0);
      check("rst_step", step, 0);
      check("rst_running", running, 1);
      for (int i = 0; i < 10; i++) begin
         tick(3);
         check($sformatf("rot_up_gap%0d", i), step, 0);
         tick(1);
         check($sformatf("rot_up_step%0d", i), step, 1);
         check($sformatf("rot_up_data%0d", i), data, (i + 1) % 8);
      end
      // ping-pong bounce at both end stops
      do_reset(2'b01);
      for (int i = 0; i < 15; i++) begin
         tick(4);
         check($sformatf("pp_data%0d", i), data, PP[i]);
      end
      // hold for 20 clocks with a dir press, then rotate down from 0
      do_reset(2'b10);
      saw_step = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 0) key_dir = 1'b0;
         if (i == 8) key_dir = 1'b1;
         tick(1);
         saw_step |= int'(step);
      end
      check("hold_no_step", saw_step, 0);
      check("hold_data", data, 0);
      mode = 2'b00;
      tick(3);
      check("down_gap", step, 0);
      tick(1);
      check("down_wrap_step", step, 1);
      check("down_wrap_data", data, 7);
      tick(4);
      check("down_next", data, 6);
      // debounce: short glitch ignored, clean press pauses, second press resumes
      do_reset(2'b00);
      key_run = 1'b0;
      tick(3);
      key_run = 1'b1;
      tick(5);
      check("glitch_running", running, 1);
      check("glitch_data", data, 2);
      key_run = 1'b0;
      tick(7);
      check("pause_running", running, 0);
      check("pause_data", data, 3);
      tick(5);
      check("pause_frozen", data, 3);
      check("pause_nostep", step, 0);
      key_run = 1'b1;
      tick(10);
      key_run = 1'b0;
      tick(6);
      check("paused_still", running, 0);
      check("paused_data", data, 3);
      tick(1);
      check("resume_running", running, 1);
      check("resume_nostep", step, 0);
      tick(1);
      check("resume_step", step, 1);
      check("resume_data", data, 4);
      key_run = 1'b1;
      tick(8);
      // dir press colliding with the ping-pong turn at 7
      do_reset(2'b01);
      tick(25);
      key_dir = 1'b0;
      tick(7);
      check("coll_data", data, 6);
      check("coll_step", step, 1);
      key_dir = 1'b1;
      tick(4);
      check("coll_next", data, 7);
      tick(4);
      check("coll_turn", data, 6);
      // reset mid-count while paused, down, and mid-debounce
      do_reset(2'b00);
      key_run = 1'b0;
      key_dir = 1'b0;
      tick(8);
      key_run = 1'b1;
      key_dir = 1'b1;
      check("pre_rst_running", running, 0);
      check("pre_rst_data", data, 1);
      tick(2);
      key_dir = 1'b0;
      tick(2);
      s_rst = 1'b1;
      tick(2);
      s_rst = 1'b0;
      key_dir = 1'b1;
      check("mid_rst_data", data, 0);
      check("mid_rst_running", running, 1);
      check("mid_rst_step", step, 0);
      tick(3);
      check("mid_rst_gap", step, 0);
      tick(1);
      check("mid_rst_first_step", step, 1);
      check("mid_rst_dir_up", data, 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
